// File: rtl/rcu_clk_seq.sv
// PLL clock-switch sequencer: bypass, reprogram, wait for stable lock (with timeout), re-enable.
// Also drops back to bypass when lock is lost while running on the PLL.
module rcu_clk_seq #(
  parameter int CFG_WIDTH     = 3,
  parameter int RST_CFG       = 0,
  parameter int TO_WIDTH      = 16,
  parameter int SWITCH_CYCLES = 8,
  parameter int SETTLE_CYCLES = 16,
  parameter int LOCK_STABLE   = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 cfg_valid_i,
  output logic                 cfg_ready_o,
  input  logic [CFG_WIDTH-1:0] cfg_i,
  input  logic [TO_WIDTH-1:0]  timeout_i,
  input  logic                 pll_lock_i,
  output logic [CFG_WIDTH-1:0] clk_cfg_o,
  output logic                 pll_en_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [1:0]           err_o,
  input  logic                 err_clr_i
);

  localparam int CNT_MAX = (SWITCH_CYCLES > SETTLE_CYCLES) ? SWITCH_CYCLES : SETTLE_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int STB_W   = $clog2(LOCK_STABLE + 1);

  localparam logic [CNT_W-1:0]     SWITCH_LAST = CNT_W'(SWITCH_CYCLES - 1);
  localparam logic [CNT_W-1:0]     SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [STB_W-1:0]     STB_LAST    = STB_W'(LOCK_STABLE - 1);
  localparam logic [CFG_WIDTH-1:0] CFG_RST     = CFG_WIDTH'(RST_CFG);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_BYPASS    = 3'd1,
    ST_PROGRAM   = 3'd2,
    ST_LOCK_WAIT = 3'd3,
    ST_ENABLE    = 3'd4
  } state_e;

  state_e               state_q;
  logic [1:0]           sync_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [STB_W-1:0]     stb_q;
  logic [TO_WIDTH-1:0]  to_cnt_q;
  logic [TO_WIDTH-1:0]  to_lat_q;
  logic [CFG_WIDTH-1:0] cfg_lat_q;
  logic [CFG_WIDTH-1:0] clk_cfg_q;
  logic                 pll_en_q;
  logic                 ready_q;
  logic                 busy_q;
  logic                 done_q;
  logic [1:0]           err_q;
  logic [1:0]           err_d;

  logic                 lock_s;
  logic [TO_WIDTH-1:0]  to_inc_s;
  logic                 to_hit_s;
  logic                 stable_hit_s;
  logic [1:0]           err_set_s;

  assign lock_s      = sync_q[1];
  assign cfg_ready_o = ready_q;
  assign clk_cfg_o   = clk_cfg_q;
  assign pll_en_o    = pll_en_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign err_o       = err_q;

  // Two-flop synchroniser for the asynchronous PLL lock
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], pll_lock_i};
    end
  end

  // Lock/timeout decisions and sticky error next-state (set beats clear)
  always_comb begin
    to_inc_s     = (to_cnt_q == {TO_WIDTH{1'b1}}) ? to_cnt_q : to_cnt_q + TO_WIDTH'(1);
    to_hit_s     = (to_lat_q != {TO_WIDTH{1'b0}}) && (to_inc_s == to_lat_q);
    stable_hit_s = lock_s && (stb_q == STB_LAST);
    err_set_s[0] = (state_q == ST_LOCK_WAIT) && to_hit_s && !stable_hit_s;
    err_set_s[1] = (state_q == ST_IDLE) && pll_en_q && !lock_s;
    err_d        = (err_q & ~{2{err_clr_i}}) | err_set_s;
  end

  // Sequencer FSM with registered outputs
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      cnt_q     <= {CNT_W{1'b0}};
      stb_q     <= {STB_W{1'b0}};
      to_cnt_q  <= {TO_WIDTH{1'b0}};
      to_lat_q  <= {TO_WIDTH{1'b0}};
      cfg_lat_q <= CFG_RST;
      clk_cfg_q <= CFG_RST;
      pll_en_q  <= 1'b0;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 2'b00;
    end else begin
      err_q  <= err_d;
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (cfg_valid_i && ready_q) begin
            cfg_lat_q <= cfg_i;
            to_lat_q  <= timeout_i;
            cnt_q     <= {CNT_W{1'b0}};
            ready_q   <= 1'b0;
            busy_q    <= 1'b1;
            pll_en_q  <= 1'b0;
            state_q   <= ST_BYPASS;
          end else if (pll_en_q && !lock_s) begin
            pll_en_q <= 1'b0;
          end
        end
        ST_BYPASS: begin
          if (cnt_q == SWITCH_LAST) begin
            cnt_q     <= {CNT_W{1'b0}};
            clk_cfg_q <= cfg_lat_q;
            state_q   <= ST_PROGRAM;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        ST_PROGRAM: begin
          if (cnt_q == SETTLE_LAST) begin
            cnt_q    <= {CNT_W{1'b0}};
            stb_q    <= {STB_W{1'b0}};
            to_cnt_q <= {TO_WIDTH{1'b0}};
            state_q  <= ST_LOCK_WAIT;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        ST_LOCK_WAIT: begin
          to_cnt_q <= to_inc_s;
          stb_q    <= lock_s ? stb_q + STB_W'(1) : {STB_W{1'b0}};
          // A lock that becomes stable on the timeout cycle still counts as success
          if (stable_hit_s) begin
            pll_en_q <= 1'b1;
            done_q   <= 1'b1;
            state_q  <= ST_ENABLE;
          end else if (to_hit_s) begin
            done_q  <= 1'b1;
            state_q <= ST_ENABLE;
          end
        end
        // Completion cycle for both outcomes: done is visible here, ready returns next
        ST_ENABLE: begin
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rcu_clk_seq.sv
// Self-checking bench for rcu_clk_seq: vector table, randomized transactions against a
// timeline model, and hand-written lock-loss / reset / back-to-back sequences.
module tb_rcu_clk_seq;

  logic       clk_i = 1'b0;
  logic       rst_i, cfg_valid_i, err_clr_i, pll_lock_i;
  logic [2:0] cfg_i;
  logic [15:0] timeout_i;
  logic       cfg_ready_o, pll_en_o, busy_o, done_o;
  logic [2:0] clk_cfg_o;
  logic [1:0] err_o;

  int n_tests = 0;
  int n_fail  = 0;
  logic [2:0] cur_cfg;
  bit sched [0:159];

  rcu_clk_seq dut (
    .clk_i(clk_i), .rst_i(rst_i), .cfg_valid_i(cfg_valid_i), .cfg_ready_o(cfg_ready_o),
    .cfg_i(cfg_i), .timeout_i(timeout_i), .pll_lock_i(pll_lock_i), .clk_cfg_o(clk_cfg_o),
    .pll_en_o(pll_en_o), .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .err_clr_i(err_clr_i)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Raw lock sched[k] is what the DUT samples at edge T+k (T = accept edge).
  // Synchronised, the FSM sees it at edge T+k+2; LOCK_WAIT occupies edges T+25 onward.
  task automatic run_txn(input string name, input logic [2:0] c, input int t,
                         input int exp_j, input bit exp_en, input logic [1:0] exp_err);
    int bad_rdy, bad_busy, bad_done, bad_en, bad_cfg, bad_err, w;
    bad_rdy = 0; bad_busy = 0; bad_done = 0; bad_en = 0; bad_cfg = 0; bad_err = 0;
    pll_lock_i = 1'b1;
    err_clr_i = 1'b1;
    tick();
    err_clr_i = 1'b0;
    check({name, ".err_cleared"}, err_o, 0);
    w = 0;
    while (!cfg_ready_o && w < 100) begin tick(); w++; end
    check({name, ".ready_before"}, cfg_ready_o, 1);
    cfg_valid_i = 1'b1; cfg_i = c; timeout_i = 16'(t);
    tick();
    cfg_valid_i = 1'b0;
    for (int j = 0; j <= exp_j + 1; j++) begin
      if (cfg_ready_o !== (j == exp_j + 1)) bad_rdy++;
      if (busy_o !== (j <= exp_j)) bad_busy++;
      if (done_o !== (j == exp_j)) bad_done++;
      if (pll_en_o !== ((j >= exp_j) ? exp_en : 1'b0)) bad_en++;
      if (clk_cfg_o !== ((j < 8) ? cur_cfg : c)) bad_cfg++;
      if (err_o !== ((j >= exp_j) ? exp_err : 2'b00)) bad_err++;
      pll_lock_i = sched[j + 1];
      if (j < exp_j + 1) tick();
    end
    pll_lock_i = 1'b1;
    check({name, ".ready_cycles_bad"}, bad_rdy, 0);
    check({name, ".busy_cycles_bad"}, bad_busy, 0);
    check({name, ".done_cycles_bad"}, bad_done, 0);
    check({name, ".pll_en_cycles_bad"}, bad_en, 0);
    check({name, ".clk_cfg_cycles_bad"}, bad_cfg, 0);
    check({name, ".err_cycles_bad"}, bad_err, 0);
    check({name, ".final_err"}, err_o, exp_err);
    cur_cfg = c;
  endtask

  typedef struct {
    logic [2:0] cfg;
    int         to;
    int         lock_at;   // first sched index held high forever; -1 = never
    bit         chatter;   // before lock_at: high 3, low 1 repeating
    int         exp_j;     // edge offset of done
    bit         exp_en;
    logic [1:0] exp_err;
  } vec_t;

  initial begin
    vec_t vecs [7];
    int e_en, e_to, exp_j, t, lk, acc_n, done_n, acc2, done_e;
    bit never, en;
    logic [2:0] c;
    logic [1:0] er;

    vecs[0] = '{3'd5, 1000, 0, 1'b0, 28, 1'b1, 2'b00};
    vecs[1] = '{3'd3, 50, -1, 1'b0, 74, 1'b0, 2'b01};
    vecs[2] = '{3'd3, 0, 0, 1'b0, 28, 1'b1, 2'b00};
    vecs[3] = '{3'd7, 0, 30, 1'b0, 35, 1'b1, 2'b00};
    vecs[4] = '{3'd1, 3, 0, 1'b0, 27, 1'b0, 2'b01};
    vecs[5] = '{3'd2, 5, 0, 1'b0, 28, 1'b1, 2'b00};
    vecs[6] = '{3'd4, 0, 40, 1'b1, 45, 1'b1, 2'b00};

    rst_i = 1'b1; cfg_valid_i = 1'b0; err_clr_i = 1'b0; pll_lock_i = 1'b1;
    cfg_i = 3'd0; timeout_i = 16'd0; cur_cfg = 3'd0;
    repeat (3) tick();
    rst_i = 1'b0;
    tick();
    check("rst.clk_cfg", clk_cfg_o, 0);
    check("rst.pll_en", pll_en_o, 0);
    check("rst.ready", cfg_ready_o, 1);
    check("rst.busy", busy_o, 0);
    check("rst.done", done_o, 0);
    check("rst.err", err_o, 0);

    foreach (vecs[i]) begin
      for (int k = 0; k < 160; k++) begin
        if (vecs[i].lock_at >= 0 && k >= vecs[i].lock_at) sched[k] = 1'b1;
        else if (vecs[i].chatter) sched[k] = ((k % 4) != 3);
        else sched[k] = 1'b0;
      end
      run_txn($sformatf("vec%0d", i), vecs[i].cfg, vecs[i].to, vecs[i].exp_j,
              vecs[i].exp_en, vecs[i].exp_err);
    end

    for (int n = 0; n < 20; n++) begin
      c = 3'($urandom_range(0, 7));
      t = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(3, 60));
      lk = $urandom_range(20, 60);
      never = (t != 0) && ($urandom_range(0, 3) == 0);
      for (int k = 0; k < 160; k++) begin
        if (never) sched[k] = ($urandom_range(0, 2) == 0);
        else if (k >= lk) sched[k] = 1'b1;
        else sched[k] = ($urandom_range(0, 3) != 0);
      end
      // Success at the first FSM edge whose last four observed lock samples were all high
      e_en = -1;
      for (int e = 28; e < 150 && e_en < 0; e++)
        if (sched[e-5] && sched[e-4] && sched[e-3] && sched[e-2]) e_en = e;
      e_to = (t == 0) ? 1000000 : 24 + t;
      if (e_en >= 0 && e_en <= e_to) begin
        exp_j = e_en; en = 1'b1; er = 2'b00;
        for (int k = e_en - 1; k < 160; k++) sched[k] = 1'b1;
      end else begin
        exp_j = e_to; en = 1'b0; er = 2'b01;
      end
      run_txn($sformatf("rnd%0d", n), c, t, exp_j, en, er);
    end

    // Lock loss while running on the PLL, then clear, then set/clear collision
    for (int k = 0; k < 160; k++) sched[k] = 1'b1;
    run_txn("ll_setup", 3'd6, 0, 28, 1'b1, 2'b00);
    tick();
    check("ll.pll_en_before", pll_en_o, 1);
    pll_lock_i = 1'b0;
    tick();
    check("ll.pll_en_edge1", pll_en_o, 1);
    tick();
    check("ll.pll_en_edge2", pll_en_o, 1);
    check("ll.err_edge2", err_o, 0);
    tick();
    check("ll.pll_en_edge3", pll_en_o, 0);
    check("ll.err_edge3", err_o, 2);
    check("ll.no_done", done_o, 0);
    err_clr_i = 1'b1;
    tick();
    err_clr_i = 1'b0;
    check("ll.err_after_clr", err_o, 0);
    tick();
    check("ll.err_stays_clear", err_o, 0);

    run_txn("sc_setup", 3'd6, 0, 28, 1'b1, 2'b00);
    tick();
    pll_lock_i = 1'b0;
    tick();
    tick();
    err_clr_i = 1'b1;
    tick();
    err_clr_i = 1'b0;
    check("setclr.err_set_wins", err_o, 2);
    check("setclr.pll_en", pll_en_o, 0);
    pll_lock_i = 1'b1;

    // cfg_valid held high: one accept per sequence, next one right after done
    acc_n = 0; done_n = 0; acc2 = -1; done_e = -1;
    cfg_i = 3'd4; timeout_i = 16'd0; cfg_valid_i = 1'b1;
    for (int i = 0; i < 56; i++) begin
      if (cfg_ready_o) begin
        acc_n++;
        if (acc_n == 2) acc2 = i;
      end
      tick();
      if (done_o) begin
        done_n++;
        done_e = i;
      end
    end
    cfg_valid_i = 1'b0;
    check("b2b.accepts", acc_n, 2);
    check("b2b.dones", done_n, 1);
    check("b2b.done_edge", done_e, 28);
    check("b2b.second_accept_edge", acc2, done_e + 2);
    for (int w = 0; w < 100 && !cfg_ready_o; w++) tick();
    check("b2b.ready_after", cfg_ready_o, 1);

    // Reset in the middle of PROGRAM
    cfg_i = 3'd6; timeout_i = 16'd0; cfg_valid_i = 1'b1;
    tick();
    cfg_valid_i = 1'b0;
    repeat (12) tick();
    check("rstmid.cfg_programmed", clk_cfg_o, 6);
    check("rstmid.busy", busy_o, 1);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    check("rstmid.clk_cfg", clk_cfg_o, 0);
    check("rstmid.pll_en", pll_en_o, 0);
    check("rstmid.ready", cfg_ready_o, 1);
    check("rstmid.busy_cleared", busy_o, 0);
    check("rstmid.err", err_o, 0);
    done_n = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done_o || !cfg_ready_o || pll_en_o) done_n++;
    end
    check("rstmid.idle_no_done", done_n, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
